t05_i2c_status_writer: RTL

- Single-byte I2C master write engine; transmits one status byte per request to a fixed-address display device.
- Sits directly upstream of the display-control stage and drives that stage's 3-bit i2c_state input with its current bus phase.
- The top-level controller supplies the byte, normally an ASCII code derived from the 4-bit controller state.
- Open-drain bus: SDA is never driven high, only released.

---
 rtl/t05_i2c_status_writer_pkg.sv | 26 ++
 rtl/t05_i2c_status_writer_if.sv | 32 +++
 rtl/t05_i2c_status_writer_tick_gen.sv | 36 +++
 rtl/t05_i2c_status_writer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/t05_i2c_status_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | t05_i2c_pkg                                                          |
// | Bus-phase enum and slot constants for the I2C status writer.         |
// | The display-control stage uses the same i2c_phase_t encoding.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package t05_i2c_pkg;

    typedef enum logic [2:0] {
        I2C_IDLE  = 3'd0,
        I2C_START = 3'd1,
        I2C_ADDR  = 3'd2,
        I2C_DATA  = 3'd3,
        I2C_ACK   = 3'd4,
        I2C_STOP  = 3'd5,
        I2C_NACK  = 3'd6,
        I2C_DONE  = 3'd7
    } i2c_phase_t;

    localparam int I2C_SLOT_TICKS = 4;
    localparam int I2C_BITS       = 8;
    localparam int I2C_MAX_RETRY  = 3;

endpackage
`default_nettype wire

// File: rtl/t05_i2c_status_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | t05_i2c_status_writer_if                                             |
// | Request/status handshake plus open-drain bus pins of the writer.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface t05_i2c_status_writer_if;
    import t05_i2c_pkg::*;

    logic       send_req;
    logic [7:0] send_data;
    logic       busy;
    logic       done;
    logic       nack;
    i2c_phase_t i2c_state;
    logic       sda_i;
    logic       scl_o;
    logic       sda_oe;

    // master: the write engine; slave: the controller / bus side feeding it
    modport master (
        input  send_req, send_data, sda_i,
        output busy, done, nack, i2c_state, scl_o, sda_oe
    );

    modport slave (
        output send_req, send_data, sda_i,
        input  busy, done, nack, i2c_state, scl_o, sda_oe
    );

endinterface
`default_nettype wire

// File: rtl/t05_i2c_status_writer_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | t05_i2c_tick_gen                                                     |
// | Quarter-bit tick: one pulse every CLK_DIV cycles after a clear.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module t05_i2c_tick_gen #(
    parameter int CLK_DIV = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    output logic      tick
);

    localparam int             c_W    = $clog2(CLK_DIV);
    localparam logic [c_W-1:0] c_LAST = c_W'(CLK_DIV - 1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/t05_i2c_status_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | t05_i2c_status_writer                                                |
// | Single-byte I2C master write of a status byte to DEV_ADDR.           |
// | Optional: T05_I2C_RETRY_EN restarts up to 3 times after a NACK.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module t05_i2c_status_writer
    import t05_i2c_pkg::*;
#(
    parameter int         CLK_DIV  = 16,
    parameter logic [6:0] DEV_ADDR = 7'h27
) (
    input  wire logic               clk,
    input  wire logic               rst,
    t05_i2c_status_writer_if.master bus
);

    localparam logic [1:0] c_PH_LAST   = 2'(I2C_SLOT_TICKS - 1);
    localparam logic [2:0] c_BIT_LAST  = 3'(I2C_BITS - 1);
    localparam logic [7:0] c_ADDR_BYTE = {DEV_ADDR, 1'b0};

    i2c_phase_t r_state;
    logic [1:0] r_ph;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_in_data;
    logic       r_ack;
    logic       r_nack_flag;
    logic       r_scl;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_done;
    logic       r_nack;
`ifdef T05_I2C_RETRY_EN
    logic [1:0] r_retry;
`endif

    logic w_tick;
    logic w_accept;

    // DONE counts as the first IDLE cycle so a held request runs back-to-back
    assign w_accept = bus.send_req && ((r_state == I2C_IDLE) || (r_state == I2C_DONE));

    t05_i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= I2C_IDLE;
            r_ph        <= 2'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'd0;
            r_data      <= 8'd0;
            r_in_data   <= 1'b0;
            r_ack       <= 1'b0;
            r_nack_flag <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
`ifdef T05_I2C_RETRY_EN
            r_retry     <= 2'd0;
`endif
        end else begin
            r_done <= 1'b0;
            r_nack <= 1'b0;
            if (w_accept) begin
                r_data      <= bus.send_data;
                r_shift     <= c_ADDR_BYTE;
                r_state     <= I2C_START;
                r_ph        <= 2'd0;
                r_bit       <= 3'd0;
                r_in_data   <= 1'b0;
                r_nack_flag <= 1'b0;
                r_busy      <= 1'b1;
`ifdef T05_I2C_RETRY_EN
                r_retry     <= 2'd0;
`endif
            end else if (r_state == I2C_DONE) begin
                r_state <= I2C_IDLE;
            end else if (r_state != I2C_IDLE && w_tick) begin
                r_ph <= r_ph + 2'd1;
                case (r_state)
                    I2C_START: begin
                        if (r_ph == 2'd1) begin
                            r_sda_oe <= 1'b1;
                        end else if (r_ph == c_PH_LAST) begin
                            r_scl   <= 1'b0;
                            r_bit   <= 3'd0;
                            r_state <= I2C_ADDR;
                        end
                    end
                    I2C_ADDR, I2C_DATA: begin
                        case (r_ph)
                            2'd0: begin
                                r_scl    <= 1'b0;
                                r_sda_oe <= ~r_shift[7];
                            end
                            2'd1: r_scl <= 1'b1;
                            2'd3: begin
                                r_scl   <= 1'b0;
                                r_shift <= {r_shift[6:0], 1'b0};
                                r_bit   <= r_bit + 3'd1;
                                if (r_bit == c_BIT_LAST) begin
                                    r_state <= I2C_ACK;
                                end
                            end
                            default: ;
                        endcase
                    end
                    I2C_ACK: begin
                        case (r_ph)
                            2'd0: r_sda_oe <= 1'b0;
                            2'd1: r_scl    <= 1'b1;
                            2'd2: r_ack    <= bus.sda_i;
                            2'd3: begin
                                r_scl <= 1'b0;
                                if (r_ack) begin
                                    r_state <= I2C_NACK;
                                end else if (r_in_data) begin
                                    r_state <= I2C_STOP;
                                end else begin
                                    r_shift   <= r_data;
                                    r_in_data <= 1'b1;
                                    r_state   <= I2C_DATA;
                                end
                            end
                            default: ;
                        endcase
                    end
                    I2C_NACK: begin
                        if (r_ph == 2'd0) begin
                            r_sda_oe <= 1'b1;
                            r_scl    <= 1'b0;
                        end else if (r_ph == c_PH_LAST) begin
                            r_nack_flag <= 1'b1;
                            r_state     <= I2C_STOP;
                        end
                    end
                    I2C_STOP: begin
                        case (r_ph)
                            2'd0: begin
                                r_sda_oe <= 1'b1;
                                r_scl    <= 1'b0;
                            end
                            2'd1: r_scl    <= 1'b1;
                            2'd2: r_sda_oe <= 1'b0;
                            2'd3: begin
`ifdef T05_I2C_RETRY_EN
                                if (r_nack_flag && (r_retry != 2'(I2C_MAX_RETRY))) begin
                                    r_retry     <= r_retry + 2'd1;
                                    r_nack_flag <= 1'b0;
                                    r_in_data   <= 1'b0;
                                    r_shift     <= c_ADDR_BYTE;
                                    r_state     <= I2C_START;
                                end else begin
                                    r_state <= I2C_DONE;
                                    r_done  <= 1'b1;
                                    r_nack  <= r_nack_flag;
                                    r_busy  <= 1'b0;
                                end
`else
                                r_state <= I2C_DONE;
                                r_done  <= 1'b1;
                                r_nack  <= r_nack_flag;
                                r_busy  <= 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.scl_o     = r_scl;
    assign bus.sda_oe    = r_sda_oe;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.nack      = r_nack;
    assign bus.i2c_state = r_state;

endmodule
`default_nettype wire
